// File: rtl/memory_pkg.sv
// Shared types and default sizing for memory_bank.
package memory_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_LED_ADDR = 10;
endpackage

// File: rtl/memory_bank_bram_sp.sv
// Synchronous block RAM: one write port, registered read, write-first on collision.
module bram_sp #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register is reset so the bank output is defined out of reset.
  always_ff @(posedge clk) begin
    if (rst)                         rdata <= '0;
    else if (re && we && raddr == waddr) rdata <= wdata;
    else if (re)                     rdata <= mem[raddr];
  end
endmodule

// File: rtl/memory_bank.sv
// A/D registers, block-RAM data memory addressed by A, and memory-mapped LEDs.
// MEMORY_BANK_CLEAR_EN: when defined, reset runs a sequencer zeroing every RAM word.
module memory_bank
  import memory_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LED_ADDR = DEF_LED_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_a_en,
  input  logic              reg_d_en,
  input  logic              reg_m_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] reg_a_out,
  output logic [DATA_W-1:0] reg_d_out,
  output logic [DATA_W-1:0] reg_m_out,
  output logic [DATA_W-1:0] leds,
  output logic              ready
);
  localparam logic [ADDR_W-1:0] LED_IDX = LED_ADDR[ADDR_W-1:0];

  state_t            state, state_nx;
  logic [ADDR_W-1:0] a_idx, addr_next, ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we, ram_re, clear_done;

  assign ready     = (state == RUN);
  assign a_idx     = reg_a_out[ADDR_W-1:0];
  // Read address follows the A value that will be visible after this edge.
  assign addr_next = (ready && reg_a_en) ? data_in[ADDR_W-1:0] : a_idx;

`ifdef MEMORY_BANK_CLEAR_EN
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
  end

  assign clear_done = (cnt == '1);
`else
  assign clear_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ram_we    = ready && reg_m_en;
    ram_waddr = a_idx;
    ram_wdata = data_in;
`ifdef MEMORY_BANK_CLEAR_EN
    ram_re    = ready;
`else
    ram_re    = 1'b1;
`endif
    case (state)
      CLEAR: begin
        if (clear_done) state_nx = RUN;
`ifdef MEMORY_BANK_CLEAR_EN
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = '0;
`endif
      end
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a_out <= '0;
      reg_d_out <= '0;
      leds      <= '0;
    end else if (ready) begin
      if (reg_a_en) reg_a_out <= data_in;
      if (reg_d_en) reg_d_out <= data_in;
      if (reg_m_en && a_idx == LED_IDX) leds <= data_in;
    end
  end

  bram_sp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (addr_next),
    .rdata (reg_m_out)
  );
endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank (ADDR_W=4); expectations follow MEMORY_BANK_CLEAR_EN.
module tb_memory_bank;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, reg_a_en, reg_d_en, reg_m_en, ready;
  logic [DATA_W-1:0] data_in, reg_a_out, reg_d_out, reg_m_out, leds;

  int checks = 0;
  int errors = 0;

  memory_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LED_ADDR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .reg_a_en  (reg_a_en),
    .reg_d_en  (reg_d_en),
    .reg_m_en  (reg_m_en),
    .data_in   (data_in),
    .reg_a_out (reg_a_out),
    .reg_d_out (reg_d_out),
    .reg_m_out (reg_m_out),
    .leds      (leds),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic d, input logic m, input logic [DATA_W-1:0] v);
    reg_a_en = a; reg_d_en = d; reg_m_en = m; data_in = v;
    step();
    reg_a_en = 0; reg_d_en = 0; reg_m_en = 0;
  endtask

  // Counts edges after release until ready is seen, bounded at 40.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n <= 40) begin
      step();
      n++;
    end
  endtask

  int n;
  int exp_len;

  initial begin
`ifdef MEMORY_BANK_CLEAR_EN
    exp_len = 16;
`else
    exp_len = 1;
`endif
    rst = 1; reg_a_en = 0; reg_d_en = 0; reg_m_en = 0; data_in = '0;
    repeat (3) step();
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_a", reg_a_out, 0);
    chk("rst_d", reg_d_out, 0);
    chk("rst_m", reg_m_out, 0);
    chk("rst_leds", leds, 0);

    // Enables presented while not ready must be ignored.
    rst = 0; reg_a_en = 1; data_in = 16'h0009;
    wait_ready(n);
    reg_a_en = 0;
    chk("clr_len", n, exp_len);
    chk("ign_a", reg_a_out, 0);
    chk("post_m", reg_m_out, 0);
`ifdef MEMORY_BANK_CLEAR_EN
    for (int i = 0; i < 16; i++) chk($sformatf("clr_mem%0d", i), dut.u_ram.mem[i], 0);
`endif

    drive(1, 0, 0, 16'h0005);
    chk("a5", reg_a_out, 16'h0005);
    drive(0, 0, 1, 16'h1234);
    chk("wr_m", reg_m_out, 16'h1234);
    chk("mem5", dut.u_ram.mem[5], 16'h1234);
    chk("leds_hold", leds, 0);

    drive(1, 0, 0, 16'h000A);
    drive(0, 0, 1, 16'h00FF);
    chk("led_m", reg_m_out, 16'h00FF);
    chk("leds", leds, 16'h00FF);
    chk("mem10", dut.u_ram.mem[10], 16'h00FF);

    drive(1, 1, 0, 16'h0007);
    chk("ad_a", reg_a_out, 16'h0007);
    chk("ad_d", reg_d_out, 16'h0007);
    drive(0, 0, 1, 16'h7777);
    drive(0, 1, 0, 16'hBEEF);
    chk("d_only", reg_d_out, 16'hBEEF);
    chk("d_a_hold", reg_a_out, 16'h0007);

    // Write lands at old A=3 while the read follows new A=7.
    drive(1, 0, 0, 16'h0003);
    drive(1, 0, 1, 16'h0007);
    chk("am_mem3", dut.u_ram.mem[3], 16'h0007);
    chk("am_a", reg_a_out, 16'h0007);
    chk("am_m", reg_m_out, 16'h7777);

    drive(1, 0, 0, 16'h0013);
    chk("alias_m", reg_m_out, 16'h0007);

    // Old index 3, new index 3 via aliasing: bypass shows the write data.
    drive(1, 0, 1, 16'h0023);
    chk("byp_m", reg_m_out, 16'h0023);
    chk("byp_mem3", dut.u_ram.mem[3], 16'h0023);
    chk("byp_leds", leds, 16'h00FF);

    rst = 1; step(); rst = 0;
`ifdef MEMORY_BANK_CLEAR_EN
    repeat (8) step();
    chk("mid_ready", {31'd0, ready}, 0);
    rst = 1; step(); rst = 0;
    wait_ready(n);
    chk("reclr_len", n, 16);
    chk("reclr_mem5", dut.u_ram.mem[5], 0);
`else
    wait_ready(n);
    chk("rerun_len", n, 1);
    chk("keep_mem5", dut.u_ram.mem[5], 16'h1234);
`endif
    chk("rerst_a", reg_a_out, 0);
    chk("rerst_leds", leds, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
